// File: rtl/chacha_qr_seq_if.sv
// chacha_qr_seq_if: input/output handshakes and ISE datapath hookup of chacha_qr_seq.
// in_iter exists only when CHACHA_QR_SEQ_ITER_EN is defined.
interface chacha_qr_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a, in_b, in_c, in_d;
`ifdef CHACHA_QR_SEQ_ITER_EN
    logic [3:0]  in_iter;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_a, out_b, out_c, out_d;
    logic [63:0] ise_rs1, ise_rs2, ise_rd;
    logic        ise_op_add, ise_op_xorrol_16, ise_op_xorrol_12, ise_op_xorrol_8, ise_op_xorrol_7;

    modport slave (
`ifdef CHACHA_QR_SEQ_ITER_EN
        input  in_iter,
`endif
        input  in_valid, in_a, in_b, in_c, in_d, out_ready, ise_rd,
        output in_ready, out_valid, out_a, out_b, out_c, out_d,
        output ise_rs1, ise_rs2,
        output ise_op_add, ise_op_xorrol_16, ise_op_xorrol_12, ise_op_xorrol_8, ise_op_xorrol_7
    );

    modport master (
`ifdef CHACHA_QR_SEQ_ITER_EN
        output in_iter,
`endif
        output in_valid, in_a, in_b, in_c, in_d, out_ready, ise_rd,
        input  in_ready, out_valid, out_a, out_b, out_c, out_d,
        input  ise_rs1, ise_rs2,
        input  ise_op_add, ise_op_xorrol_16, ise_op_xorrol_12, ise_op_xorrol_8, ise_op_xorrol_7
    );
endinterface

// File: rtl/chacha_qr_seq.sv
// chacha_qr_seq: steps a packed ChaCha ISE datapath through the 8-step quarter-round.
// Define CHACHA_QR_SEQ_ITER_EN to add in_iter and run max(in_iter,1) chained passes.
module chacha_qr_seq (
    input logic g_clk,
    input logic g_resetn,
    chacha_qr_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state, state_nxt;
    logic [63:0] a, b, c, d;
    logic [2:0]  step;
    logic        accept, last, run;

    assign accept = bus.in_valid && state == IDLE;

`ifdef CHACHA_QR_SEQ_ITER_EN
    logic [3:0] pass;
    always_ff @(posedge g_clk or negedge g_resetn)
        if (!g_resetn)
            pass <= '0;
        else if (accept)
            pass <= (bus.in_iter == 4'd0) ? 4'd1 : bus.in_iter;
        else if (run && step == 3'd7)
            pass <= pass - 4'd1;
    assign last = pass == 4'd1;
`else
    assign last = 1'b1;
`endif

    always_ff @(posedge g_clk or negedge g_resetn)
        if (!g_resetn)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.in_valid ? RUN : IDLE;
            RUN:     state_nxt = (step == 3'd7 && last) ? DONE : RUN;
            DONE:    state_nxt = bus.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Destination of every step is the register that fed rs1.
    always_ff @(posedge g_clk or negedge g_resetn)
        if (!g_resetn) begin
            step <= '0;
            a    <= '0;
            b    <= '0;
            c    <= '0;
            d    <= '0;
        end else if (accept) begin
            step <= '0;
            a    <= bus.in_a;
            b    <= bus.in_b;
            c    <= bus.in_c;
            d    <= bus.in_d;
        end else if (run) begin
            step <= step + 3'd1;
            case (step[1:0])
                2'd0:    a <= bus.ise_rd;
                2'd1:    d <= bus.ise_rd;
                2'd2:    c <= bus.ise_rd;
                default: b <= bus.ise_rd;
            endcase
        end

    always_comb begin
        run                  = state == RUN;
        bus.in_ready         = state == IDLE;
        bus.out_valid        = state == DONE;
        bus.ise_rs1          = !run ? 64'd0 :
                               step[1:0] == 2'd0 ? a :
                               step[1:0] == 2'd1 ? d :
                               step[1:0] == 2'd2 ? c : b;
        bus.ise_rs2          = !run ? 64'd0 :
                               step[1:0] == 2'd0 ? b :
                               step[1:0] == 2'd1 ? a :
                               step[1:0] == 2'd2 ? d : c;
        bus.ise_op_add       = run && !step[0];
        bus.ise_op_xorrol_16 = run && step == 3'd1;
        bus.ise_op_xorrol_12 = run && step == 3'd3;
        bus.ise_op_xorrol_8  = run && step == 3'd5;
        bus.ise_op_xorrol_7  = run && step == 3'd7;
    end

    assign bus.out_a = a;
    assign bus.out_b = b;
    assign bus.out_c = c;
    assign bus.out_d = d;
endmodule

// File: tb/tb_chacha_qr_seq.sv
// tb_chacha_qr_seq: scoreboard bench for chacha_qr_seq with a behavioural ISE datapath
// and a plain-arithmetic ChaCha quarter-round reference model.
module tb_chacha_qr_seq;
    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    chacha_qr_seq_if bus ();
    chacha_qr_seq dut (.g_clk(g_clk), .g_resetn(g_resetn), .bus(bus));

    localparam logic [63:0] RA = 64'h11111111_11111111, RB = 64'h01020304_01020304;
    localparam logic [63:0] RC = 64'h9b8d6f43_9b8d6f43, RD = 64'h01234567_01234567;
    localparam logic [255:0] RFC_OUT = {64'hea2a92f4_ea2a92f4, 64'hcb1cf8ce_cb1cf8ce,
                                        64'h4581472e_4581472e, 64'h5881c4bb_5881c4bb};

    typedef struct {
        logic [63:0] a, b, c, d;
        int c0;
        int n;
    } exp_t;

    exp_t         q[$];
    int           tests = 0, fails = 0, cyc = 0;
    logic         rand_rdy = 1'b0;
    logic [4:0]   ops;
    logic [255:0] last_out = '0;
    logic [4:0]   pat [8] = '{5'b10000, 5'b01000, 5'b10000, 5'b00100,
                              5'b10000, 5'b00010, 5'b10000, 5'b00001};

    function automatic logic [31:0] rol(logic [31:0] x, int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Behavioural ISE datapath: per-lane add or xor-then-rotate.
    function automatic logic [63:0] dp(logic [63:0] x, logic [63:0] y, logic [4:0] op);
        logic [63:0] r;
        logic [31:0] p, s, t;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            p = x[32*l +: 32];
            s = y[32*l +: 32];
            t = p ^ s;
            r[32*l +: 32] = op[4] ? p + s : op[3] ? rol(t, 16) : op[2] ? rol(t, 12) :
                            op[1] ? rol(t, 8) : op[0] ? rol(t, 7) : 32'd0;
        end
        return r;
    endfunction

    assign ops = {bus.ise_op_add, bus.ise_op_xorrol_16, bus.ise_op_xorrol_12,
                  bus.ise_op_xorrol_8, bus.ise_op_xorrol_7};
    assign bus.ise_rd = dp(bus.ise_rs1, bus.ise_rs2, ops);

    function automatic logic [127:0] qr(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
        a = a + b; d = rol(d ^ a, 16);
        c = c + d; b = rol(b ^ c, 12);
        a = a + b; d = rol(d ^ a, 8);
        c = c + d; b = rol(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic [63:0] c, logic [63:0] d, int n);
        exp_t e;
        logic [127:0] r;
        for (int p = 0; p < n; p++)
            for (int l = 0; l < 2; l++) begin
                r = qr(a[32*l +: 32], b[32*l +: 32], c[32*l +: 32], d[32*l +: 32]);
                a[32*l +: 32] = r[127:96];
                b[32*l +: 32] = r[95:64];
                c[32*l +: 32] = r[63:32];
                d[32*l +: 32] = r[31:0];
            end
        e.a = a; e.b = b; e.c = c; e.d = d; e.c0 = 0; e.n = n;
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge g_clk) cyc <= cyc + 1;

    always @(posedge g_clk) begin
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: checks op sequencing, idle operands, handshakes and pops results.
    logic prev_v = 1'b0, prev_hs = 1'b0;
    logic [255:0] snap = '0;
    always @(negedge g_clk) begin
        logic [4:0] eop;
        int k;
        exp_t e;
        eop = '0;
        if (q.size() != 0) begin
            k = cyc - q[0].c0;
            if (k >= 1 && k <= 8 * q[0].n) eop = pat[(k - 1) % 8];
        end
        chk("ops", 256'(ops), 256'(eop));
        if (eop == 5'd0) begin
            chk("rs1_idle", 256'(bus.ise_rs1), 256'd0);
            chk("rs2_idle", 256'(bus.ise_rs2), 256'd0);
        end else
            chk("in_ready_run", 256'(bus.in_ready), 256'd0);
        if (prev_hs) begin
            chk("in_ready_after_hs", 256'(bus.in_ready), 256'd1);
            chk("out_valid_after_hs", 256'(bus.out_valid), 256'd0);
        end
        if (bus.out_valid) begin
            chk("in_ready_done", 256'(bus.in_ready), 256'd0);
            if (!prev_v) begin
                snap = {bus.out_a, bus.out_b, bus.out_c, bus.out_d};
                last_out = snap;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("latency", 256'(cyc - e.c0), 256'(8 * e.n + 1));
                    chk("result", snap, {e.a, e.b, e.c, e.d});
                end
            end else
                chk("stable", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, snap);
        end
        prev_v  = bus.out_valid && !bus.out_ready;
        prev_hs = bus.out_valid && bus.out_ready;
    end

    task automatic send(logic [63:0] a, logic [63:0] b, logic [63:0] c, logic [63:0] d, int iter);
        exp_t e;
        int n;
        logic ok;
        ok = 1'b0;
        n = 1;
        @(posedge g_clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
`ifdef CHACHA_QR_SEQ_ITER_EN
        bus.in_iter = 4'(iter);
        n = (iter == 0) ? 1 : iter;
`endif
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge g_clk);
            ok = bus.in_ready;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 (cycle %0d)", cyc);
        end else begin
            e = model(a, b, c, d, n);
            e.c0 = cyc;
            q.push_back(e);
        end
        @(posedge g_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a = rnd64(); bus.in_b = rnd64(); bus.in_c = rnd64(); bus.in_d = rnd64();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge g_clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got %0d pending expected 0 (cycle %0d)", q.size(), cyc);
            q.delete();
        end
        repeat (3) @(negedge g_clk);
    endtask

    initial begin
        exp_t e;
        logic ok;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
`ifdef CHACHA_QR_SEQ_ITER_EN
        bus.in_iter = '0;
`endif
        repeat (2) @(posedge g_clk);
        #1;
        chk("reset_in_ready", 256'(bus.in_ready), 256'd1);
        chk("reset_out_valid", 256'(bus.out_valid), 256'd0);
        chk("reset_regs", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, 256'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;

        send(RA, RB, RC, RD, 1);
        wait_idle();
        chk("rfc_vector", last_out, RFC_OUT);

        send({RA[63:32], 32'd0}, {RB[63:32], 32'd0}, {RC[63:32], 32'd0}, {RD[63:32], 32'd0}, 1);
        wait_idle();
        chk("lane_independence", last_out, {RFC_OUT[255:224], 32'd0, RFC_OUT[191:160], 32'd0,
                                            RFC_OUT[127:96], 32'd0, RFC_OUT[63:32], 32'd0});

        // Backpressure with a stray in_valid while the result is held.
        @(posedge g_clk);
        #1;
        bus.out_ready = 1'b0;
        send(rnd64(), rnd64(), rnd64(), rnd64(), 1);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge g_clk);
            ok = bus.out_valid;
        end
        chk("bp_out_valid_seen", 256'(ok), 256'd1);
        repeat (20) begin
            @(posedge g_clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_a = rnd64(); bus.in_b = rnd64(); bus.in_c = rnd64(); bus.in_d = rnd64();
        end
        @(posedge g_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a run.
        send(RA, RB, RC, RD, 1);
        repeat (3) @(posedge g_clk);
        #2;
        q.delete();
        g_resetn = 1'b0;
        #1;
        chk("midreset_in_ready", 256'(bus.in_ready), 256'd1);
        chk("midreset_out_valid", 256'(bus.out_valid), 256'd0);
        chk("midreset_ise", {bus.ise_rs1, bus.ise_rs2, 123'd0, ops}, 256'd0);
        chk("midreset_regs", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, 256'd0);
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        send(RA, RB, RC, RD, 1);
        wait_idle();
        chk("post_reset_rfc", last_out, RFC_OUT);

`ifdef CHACHA_QR_SEQ_ITER_EN
        send(RA, RB, RC, RD, 2);
        wait_idle();
        e = model(RFC_OUT[255:192], RFC_OUT[191:128], RFC_OUT[127:64], RFC_OUT[63:0], 1);
        chk("iter2_chained", last_out, {e.a, e.b, e.c, e.d});
        send(RA, RB, RC, RD, 0);
        wait_idle();
        chk("iter0_as_one", last_out, RFC_OUT);
`endif

        for (int t = 0; t < 24; t++) begin
            if (t == 12) rand_rdy = 1'b1;
            send(rnd64(), rnd64(), rnd64(), rnd64(), int'($urandom_range(0, 3)));
        end
        @(posedge g_clk);
        #3;
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
